// File: rtl/trig_pulse_gen.sv
// Ultrasonic trigger driver: turns a request strobe into a fixed-width
// pulse followed by a hold-off, with one request slot queued while busy.
module trig_pulse_gen #(
  parameter int unsigned T_TRIG = 1250,
  parameter int unsigned T_HOLD = 7_500_000,
  parameter int unsigned CNT_W  = 23
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic trig_out,
  output logic busy,
  output logic done,
  output logic overrun
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(T_TRIG - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(T_HOLD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    trig_d  = trig_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PULSE;
          cnt_d   = '0;
          trig_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      PULSE: begin
        if (start) begin
          if (pend_q) ovr_d = 1'b1;
          else        pend_d = 1'b1;
        end
        if (cnt_q == TRIG_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          trig_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          done_d = 1'b1;
          cnt_d  = '0;
          // terminal cycle consumes start directly, no overrun here
          if (pend_q || start) begin
            state_d = PULSE;
            trig_d  = 1'b1;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (start) begin
            if (pend_q) ovr_d = 1'b1;
            else        pend_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
        trig_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign trig_out = trig_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Bench for trig_pulse_gen: two instances (4/6 and 1/1 timing) against a
// launch-time reference model, directed scenarios then random traffic.
module tb_trig_pulse_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic trig0, busy0, done0, ovr0;
  logic trig1, busy1, done1, ovr1;

  int n_cmp = 0;
  int n_err = 0;
  int t = 0;

  int unsigned tt [2] = '{4, 1};
  int unsigned th [2] = '{6, 1};
  bit m_act [2];
  bit m_pend [2];
  int m_l [2];
  bit e_trig [2];
  bit e_busy [2];
  bit e_done [2];
  bit e_ovr [2];

  always #5 clk = ~clk;

  trig_pulse_gen #(.T_TRIG(4), .T_HOLD(6), .CNT_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .trig_out(trig0), .busy(busy0), .done(done0), .overrun(ovr0)
  );

  trig_pulse_gen #(.T_TRIG(1), .T_HOLD(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .trig_out(trig1), .busy(busy1), .done(done1), .overrun(ovr1)
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_pend[i] = 0; m_l[i] = 0;
      e_trig[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_ovr[i] = 0;
    end
  endtask

  // One launch every T_TRIG+T_HOLD edges, measured from the launch edge.
  task automatic model_edge(input bit s);
    for (int i = 0; i < 2; i++) begin
      e_done[i] = 0;
      e_ovr[i] = 0;
      if (!m_act[i]) begin
        if (s) begin m_act[i] = 1; m_l[i] = t; end
      end else if (t - m_l[i] == int'(tt[i] + th[i])) begin
        e_done[i] = 1;
        if (m_pend[i] || s) begin m_l[i] = t; m_pend[i] = 0; end
        else m_act[i] = 0;
      end else if (s) begin
        if (m_pend[i]) e_ovr[i] = 1;
        else m_pend[i] = 1;
      end
      e_busy[i] = m_act[i];
      e_trig[i] = m_act[i] && (t - m_l[i] < int'(tt[i]));
    end
  endtask

  task automatic chk(input string tag, input logic obs, input bit exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("trig0", trig0, e_trig[0]);
    chk("busy0", busy0, e_busy[0]);
    chk("done0", done0, e_done[0]);
    chk("ovr0", ovr0, e_ovr[0]);
    chk("trig1", trig1, e_trig[1]);
    chk("busy1", busy1, e_busy[1]);
    chk("done1", done1, e_done[1]);
    chk("ovr1", ovr1, e_ovr[1]);
  endtask

  task automatic step(input bit s);
    @(negedge clk);
    start = s;
    @(posedge clk);
    t++;
    model_edge(s);
    #1;
    chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic pattern(input int a, input int b, input int c);
    for (int i = 0; i < 30; i++) step(i == a || i == b || i == c);
  endtask

  initial begin
    model_reset();
    #2;
    chk_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    idle(20);
    pattern(5, -1, -1);
    pattern(5, 8, -1);
    pattern(5, 8, 11);
    pattern(5, 15, -1);
    pattern(5, 6, 7);
    pattern(1, 11, 12);

    step(1'b1);
    idle(3);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    @(negedge clk);
    rst_n = 1'b1;
    pattern(5, -1, -1);

    for (int ph = 0; ph < 4; ph++) begin
      int pct;
      pct = (ph == 0) ? 5 : (ph == 1) ? 20 : (ph == 2) ? 50 : 90;
      for (int i = 0; i < 300; i++)
        step($urandom_range(0, 99) < pct);
    end
    idle(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
